// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack for nested calls.
// Overflow or underflow of the stack latches a fault that only reset clears.
module pc_stack_unit #(
  parameter int PC_WIDTH    = 5,
  parameter int STACK_DEPTH = 4,
  parameter int SP_WIDTH    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                jmp,
  input  logic                cal,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] jmp_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [SP_WIDTH-1:0] sp,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                fault,
  output logic [1:0]          fault_code
);

  localparam int IDX_W = SP_WIDTH - 1;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;
  localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SP_WIDTH-1:0] SP_ONE  = {{(SP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SP_WIDTH-1:0] SP_ZERO = {SP_WIDTH{1'b0}};
  localparam logic [SP_WIDTH-1:0] SP_FULL = SP_WIDTH'(STACK_DEPTH);

  logic [0:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SP_WIDTH-1:0] sp_q, sp_d;
  logic [1:0]          code_q, code_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                push_s;
  logic [PC_WIDTH-1:0] pc_inc_s;
  logic [SP_WIDTH-1:0] sp_dec_s;
  logic [IDX_W-1:0]    push_idx_s;
  logic [PC_WIDTH-1:0] pop_data_s;

  assign pc_inc_s   = pc_q + PC_ONE;
  assign sp_dec_s   = sp_q - SP_ONE;
  assign push_idx_s = sp_q[IDX_W-1:0];
  // sp_q never exceeds STACK_DEPTH, so the low bits address the top entry
  assign pop_data_s = stack_q[sp_dec_s[IDX_W-1:0]];

  // Next-state decode; strobe priority is cal > jmp > ret > sequential step
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    code_d  = code_q;
    push_s  = 1'b0;
    if ((state_q == ST_RUN) && en) begin
      if (cal) begin
        if (sp_q == SP_FULL) begin
          state_d = ST_FAULT;
          code_d  = 2'b01;
        end else begin
          push_s = 1'b1;
          sp_d   = sp_q + SP_ONE;
          pc_d   = jmp_addr;
        end
      end else if (jmp) begin
        pc_d = jmp_addr;
      end else if (ret) begin
        if (sp_q == SP_ZERO) begin
          state_d = ST_FAULT;
          code_d  = 2'b10;
        end else begin
          pc_d = pop_data_s;
          sp_d = sp_dec_s;
        end
      end else begin
        pc_d = pc_inc_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= {PC_WIDTH{1'b0}};
      sp_q    <= SP_ZERO;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      code_q  <= code_d;
    end
  end

  // Return-address storage; popped entries keep their contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= {PC_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      stack_q[push_idx_s] <= pc_inc_s;
    end else begin
      stack_q[push_idx_s] <= stack_q[push_idx_s];
    end
  end

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign fault       = (state_q == ST_FAULT);
  assign fault_code  = code_q;
  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == SP_ZERO);

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: sequential stepping, calls/returns,
// overflow/underflow faults, enable gating and asynchronous reset.
module tb_pc_stack_unit;

  logic       clk;
  logic       rst;
  logic       en;
  logic       jmp;
  logic       cal;
  logic       ret;
  logic [4:0] jmp_addr;
  logic [4:0] pc;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  pc_stack_unit #(.PC_WIDTH(5), .STACK_DEPTH(4), .SP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .jmp(jmp), .cal(cal), .ret(ret),
    .jmp_addr(jmp_addr), .pc(pc), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_pc, input int e_sp,
                         input int e_fault, input int e_code);
    chk({tag, " pc"}, int'(pc), e_pc);
    chk({tag, " sp"}, int'(sp), e_sp);
    chk({tag, " fault"}, int'(fault), e_fault);
    chk({tag, " code"}, int'(fault_code), e_code);
    chk({tag, " full"}, int'(stack_full), (e_sp == 4) ? 1 : 0);
    chk({tag, " empty"}, int'(stack_empty), (e_sp == 0) ? 1 : 0);
  endtask

  // Apply one set of inputs across one rising edge, return 1 time unit later.
  task automatic step(input logic e, input logic c, input logic j,
                      input logic r, input logic [4:0] a);
    en = e; cal = c; jmp = j; ret = r; jmp_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_all(tag, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; jmp = 1'b0; cal = 1'b0; ret = 1'b0; jmp_addr = 5'd0;
    #12;
    chk_all("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 33 plain edges: 1..31, 0, 1
    for (int k = 1; k <= 33; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      chk("seq pc", int'(pc), k % 32);
    end
    chk_all("seq end", 1, 0, 0, 0);

    // Reach pc=3, call 20, two plain edges, return to 4
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("at3 pc", int'(pc), 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd20);
    chk_all("call20", 20, 1, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("call20+1 pc", int'(pc), 21);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("call20+2 pc", int'(pc), 22);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_all("ret to 4", 4, 0, 0, 0);

    // Nested calls at pc=1,11,21,31 with targets 10,20,30,5
    pulse_reset("mid rst");
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("pc1", int'(pc), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd10);
    chk_all("nest1", 10, 1, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd20);
    chk_all("nest2", 20, 2, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd30);
    chk_all("nest3", 30, 3, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("pc31", int'(pc), 31);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
    chk_all("nest4", 5, 4, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_all("unwind1", 0, 3, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_all("unwind2", 22, 2, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_all("unwind3", 12, 1, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_all("unwind4", 2, 0, 0, 0);

    // Refill to 4 entries with target 15, then overflow
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 5'd15);
      chk("refill sp", int'(sp), k);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
    chk_all("overflow", 15, 4, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_all("ovf ret frozen", 15, 4, 1, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
    chk_all("ovf jmp frozen", 15, 4, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_all("ovf step frozen", 15, 4, 1, 1);
    pulse_reset("ovf rst");

    // Underflow on the first enabled edge, then a call is ignored
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_all("underflow", 0, 0, 1, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
    chk_all("udf cal ignored", 0, 0, 1, 2);
    pulse_reset("udf rst");

    // en=0 gating with jmp held
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'd9);
      chk("en0 hold pc", int'(pc), 0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
    chk_all("jmp9", 9, 0, 0, 0);
    // ret+jmp: jmp wins, no underflow fault
    step(1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    chk_all("jmp beats ret", 3, 0, 0, 0);

    // Two nested calls, then asynchronous reset between edges
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd12);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
    chk_all("sp2", 6, 2, 0, 0);
    #2;
    pulse_reset("async rst");
    // stack is empty again after reset, so a ret must underflow
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_all("post rst ret", 0, 0, 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
